// File: rtl/banked_sram_ext_if.sv
// RW0 single-port memory bus seen by banked_sram_ext.
// The master drives the access; the wrapper returns read data and readiness.
interface banked_sram_ext_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int MASK_W = 4
);
  logic [ADDR_W-1:0] RW0_addr;
  logic              RW0_en;
  logic              RW0_wmode;
  logic [MASK_W-1:0] RW0_wmask;
  logic [DATA_W-1:0] RW0_wdata;
  logic [DATA_W-1:0] RW0_rdata;
  logic              init_done;

  modport master (
    output RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata,
    input  RW0_rdata, init_done
  );

  modport slave (
    input  RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata,
    output RW0_rdata, init_done
  );
endinterface

// File: rtl/banked_sram_ext.sv
// Banked SRAM wrapper: one RW0 single-port memory spread over NBANKS dual-port macros (port 0 only).
// Define MARMOT_SRAM_INIT_EN to compile in the post-reset zero-fill sequencer.
module banked_sram_ext #(
  parameter int  ADDR_W      = 10,
  parameter int  BANK_ADDR_W = 9,
  parameter int  DATA_W      = 32,
  parameter int  MASK_W      = 4,
  localparam int NBANKS      = 1 << (ADDR_W - BANK_ADDR_W),
  localparam int BYTES       = DATA_W / 8
) (
  input  logic                          RW0_clk,
  input  logic                          reset,
  banked_sram_ext_if.slave              bus,
  output logic [NBANKS-1:0]             ram_clk,
  output logic [NBANKS-1:0]             ram_csb0,
  output logic [NBANKS-1:0]             ram_web0,
  output logic [NBANKS*BYTES-1:0]       ram_wmask0,
  output logic [NBANKS*BANK_ADDR_W-1:0] ram_addr0,
  output logic [NBANKS*DATA_W-1:0]      ram_din0,
  input  logic [NBANKS*DATA_W-1:0]      ram_dout0,
  output logic [NBANKS-1:0]             ram_csb1,
  output logic [NBANKS*BANK_ADDR_W-1:0] ram_addr1
);
  localparam int R     = BYTES / MASK_W;
  localparam int SEL_W = (ADDR_W > BANK_ADDR_W) ? (ADDR_W - BANK_ADDR_W) : 1;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_INIT  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  state_t                 state_reg;
  state_t                 state_next;
  logic [NBANKS-1:0]      bank_hit;
  logic [BYTES-1:0]       wmask_exp;
  logic [BANK_ADDR_W-1:0] fill_addr;
  logic                   fill_last;
  logic                   rd_req;
  logic                   rd_pend_reg;
  logic [NBANKS-1:0]      rd_sel_reg;
  logic [DATA_W-1:0]      hold_reg;
  logic [DATA_W-1:0]      rd_data;
  logic [DATA_W-1:0]      bank_rdata [NBANKS];

  assign ram_clk   = {NBANKS{RW0_clk}};
  assign ram_csb1  = '1;
  assign ram_addr1 = '1;

  generate
    if (NBANKS == 1) begin : g_one_bank
      assign bank_hit = 1'b1;
    end else begin : g_multi_bank
      for (genvar gi = 0; gi < NBANKS; gi++) begin : g_hit
        assign bank_hit[gi] = (bus.RW0_addr[ADDR_W-1:BANK_ADDR_W] == SEL_W'(gi));
      end
    end
  endgenerate

  // Each mask lane covers R consecutive macro byte enables.
  generate
    for (genvar gi = 0; gi < MASK_W; gi++) begin : g_mask
      assign wmask_exp[gi*R +: R] = {R{bus.RW0_wmask[gi]}};
    end
  endgenerate

`ifdef MARMOT_SRAM_INIT_EN
  logic [BANK_ADDR_W-1:0] count_reg;

  // Counter only runs in INIT, so an interrupted fill always restarts at 0.
  always_ff @(posedge RW0_clk) begin
    if (reset || state_reg != ST_INIT) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + BANK_ADDR_W'(1);
    end
  end

  assign fill_addr = count_reg;
  assign fill_last = (count_reg == '1);
`else
  assign fill_addr = '0;
  assign fill_last = 1'b1;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RESET: begin
`ifdef MARMOT_SRAM_INIT_EN
        state_next = ST_INIT;
`else
        state_next = ST_READY;
`endif
      end
      ST_INIT: begin
        if (fill_last) begin
          state_next = ST_READY;
        end
      end
      ST_READY: state_next = ST_READY;
      default:  state_next = ST_RESET;
    endcase
  end

  always_comb begin
    ram_csb0   = '1;
    ram_web0   = '1;
    ram_wmask0 = {NBANKS{wmask_exp}};
    ram_addr0  = {NBANKS{bus.RW0_addr[BANK_ADDR_W-1:0]}};
    ram_din0   = {NBANKS{bus.RW0_wdata}};
    case (state_reg)
      ST_INIT: begin
        ram_csb0   = '0;
        ram_web0   = '0;
        ram_wmask0 = '1;
        ram_addr0  = {NBANKS{fill_addr}};
        ram_din0   = '0;
      end
      ST_READY: begin
        ram_csb0 = ~(bank_hit & {NBANKS{bus.RW0_en}});
        ram_web0 = {NBANKS{~bus.RW0_wmode}};
      end
      default: ;
    endcase
  end

  // Reads only count once READY; anything presented earlier is silently dropped.
  assign rd_req = (state_reg == ST_READY) & bus.RW0_en & ~bus.RW0_wmode;

  generate
    for (genvar gi = 0; gi < NBANKS; gi++) begin : g_rd
      assign bank_rdata[gi] = rd_sel_reg[gi] ? ram_dout0[gi*DATA_W +: DATA_W] : '0;
    end
  endgenerate

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NBANKS; k++) begin
      rd_data = rd_data | bank_rdata[k];
    end
  end

  always_ff @(posedge RW0_clk) begin
    if (reset) begin
      state_reg   <= ST_RESET;
      rd_pend_reg <= 1'b0;
      rd_sel_reg  <= '0;
      hold_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      rd_pend_reg <= rd_req;
      rd_sel_reg  <= rd_req ? bank_hit : '0;
      if (rd_pend_reg) begin
        hold_reg <= rd_data;
      end
    end
  end

  // The macro output is only trusted in the cycle after a read; the hold register covers the rest.
  assign bus.RW0_rdata = rd_pend_reg ? rd_data : hold_reg;
  assign bus.init_done = (state_reg == ST_READY);
endmodule

// File: tb/tb_banked_sram_ext.sv
// Randomized scoreboard bench for banked_sram_ext with behavioural macros and a flat reference memory.
`timescale 1ns/1ps
module tb_banked_sram_ext;
  localparam int ADDR_W      = 11;
  localparam int BANK_ADDR_W = 9;
  localparam int DATA_W      = 64;
  localparam int MASK_W      = 2;
  localparam int NBANKS      = 4;
  localparam int BYTES       = 8;
  localparam int DEPTH       = 2048;
  localparam int BDEPTH      = 512;
`ifdef MARMOT_SRAM_INIT_EN
  localparam int FILL_EDGES  = BDEPTH + 1;
`else
  localparam int FILL_EDGES  = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NBANKS-1:0]             ram_clk, ram_csb0, ram_web0, ram_csb1;
  logic [NBANKS*BYTES-1:0]       ram_wmask0;
  logic [NBANKS*BANK_ADDR_W-1:0] ram_addr0, ram_addr1;
  logic [NBANKS*DATA_W-1:0]      ram_din0, ram_dout0;

  banked_sram_ext_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) bus ();

  banked_sram_ext #(
    .ADDR_W(ADDR_W), .BANK_ADDR_W(BANK_ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)
  ) dut (
    .RW0_clk(clk), .reset(reset), .bus(bus),
    .ram_clk(ram_clk), .ram_csb0(ram_csb0), .ram_web0(ram_web0),
    .ram_wmask0(ram_wmask0), .ram_addr0(ram_addr0), .ram_din0(ram_din0),
    .ram_dout0(ram_dout0), .ram_csb1(ram_csb1), .ram_addr1(ram_addr1)
  );

  always #5 clk = ~clk;

  // Behavioural sky130-style macros: registered read, byte-masked write, seeded with garbage.
  for (genvar gi = 0; gi < NBANKS; gi++) begin : g_macro
    logic [DATA_W-1:0] mem [BDEPTH];
    logic [DATA_W-1:0] dout_r;
    logic              seeded = 1'b0;
    always @(posedge clk) begin
      if (!seeded) begin
        for (int a = 0; a < BDEPTH; a++) mem[a] <= {$urandom, $urandom};
        dout_r <= {$urandom, $urandom};
        seeded <= 1'b1;
      end else if (!ram_csb0[gi]) begin
        if (!ram_web0[gi]) begin
          for (int b = 0; b < BYTES; b++)
            if (ram_wmask0[gi*BYTES+b])
              mem[ram_addr0[gi*BANK_ADDR_W +: BANK_ADDR_W]][b*8 +: 8] <= ram_din0[gi*DATA_W + b*8 +: 8];
        end else begin
          dout_r <= mem[ram_addr0[gi*BANK_ADDR_W +: BANK_ADDR_W]];
        end
      end
    end
    assign ram_dout0[gi*DATA_W +: DATA_W] = dout_r;
  end

  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] last_exp = '0;
  logic              m_have, m_rst;
  int                n_cmp = 0;
  int                n_fail = 0;
  int                n_edges;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Read data returns the cycle after its request; otherwise the last read value must persist.
  always @(posedge clk) begin
    m_have = (exp_q.size() != 0);
    m_rst  = reset;
    #1;
    if (m_rst) last_exp = '0;
    if (m_have) begin
      last_exp = exp_q.pop_front();
      check("rdata", bus.RW0_rdata, last_exp);
    end else begin
      check("hold", bus.RW0_rdata, last_exp);
    end
  end

  function automatic logic [BYTES-1:0] byte_mask(input logic [MASK_W-1:0] m);
    logic [BYTES-1:0] r;
    r = '0;
    for (int b = 0; b < BYTES; b++) r[b] = m[b / (BYTES / MASK_W)];
    return r;
  endfunction

  task automatic junk();
    bus.RW0_en    = 1'($urandom_range(0, 1));
    bus.RW0_wmode = 1'($urandom_range(0, 1));
    bus.RW0_addr  = ADDR_W'($urandom);
    bus.RW0_wdata = {$urandom, $urandom};
    bus.RW0_wmask = MASK_W'($urandom);
  endtask

  task automatic op(input bit en, input bit wr, input logic [ADDR_W-1:0] addr,
                    input logic [DATA_W-1:0] data, input logic [MASK_W-1:0] mask);
    int               bank;
    logic [BYTES-1:0] bm;
    logic [NBANKS-1:0] ecsb, ewe;
    bank = int'(addr[ADDR_W-1:BANK_ADDR_W]);
    bm   = byte_mask(mask);
    @(negedge clk);
    bus.RW0_en = en; bus.RW0_wmode = wr; bus.RW0_addr = addr;
    bus.RW0_wdata = data; bus.RW0_wmask = mask;
    if (en && wr)
      for (int b = 0; b < BYTES; b++)
        if (bm[b]) ref_mem[addr][b*8 +: 8] = data[b*8 +: 8];
    if (en && !wr) exp_q.push_back(ref_mem[addr]);
    #1;
    ecsb = en ? ~(NBANKS'(1) << bank) : '1;
    ewe  = wr ? '0 : '1;
    check("csb0", DATA_W'(ram_csb0), DATA_W'(ecsb));
    check("web0", DATA_W'(ram_web0), DATA_W'(ewe));
    if (en) check("addr0", DATA_W'(ram_addr0[bank*BANK_ADDR_W +: BANK_ADDR_W]), DATA_W'(addr[BANK_ADDR_W-1:0]));
    if (en && wr) begin
      check("din0", ram_din0[bank*DATA_W +: DATA_W], data);
      check("wmask0", DATA_W'(ram_wmask0[bank*BYTES +: BYTES]), DATA_W'(bm));
    end
  endtask

  task automatic wr(input int a, input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] m);
    op(1'b1, 1'b1, ADDR_W'(a), d, m);
  endtask

  task automatic rd(input int a);
    op(1'b1, 1'b0, ADDR_W'(a), {$urandom, $urandom}, MASK_W'($urandom));
  endtask

  task automatic idle();
    op(1'b0, 1'($urandom_range(0, 1)), ADDR_W'($urandom), {$urandom, $urandom}, MASK_W'($urandom));
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      reset = 1'b1;
      junk();
      @(posedge clk);
      #1;
      check("rst_csb0", DATA_W'(ram_csb0), DATA_W'({NBANKS{1'b1}}));
      check("rst_web0", DATA_W'(ram_web0), DATA_W'({NBANKS{1'b1}}));
      check("rst_init_done", DATA_W'(bus.init_done), '0);
    end
    @(negedge clk);
    reset = 1'b0;
    junk();
  endtask

  // Counts edges after release until init_done; during zero-fill the macro port is checked every cycle.
  task automatic wait_init(input int limit, output int n);
    n = 0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.init_done) break;
`ifdef MARMOT_SRAM_INIT_EN
      check("init_csb0", DATA_W'(ram_csb0), '0);
      check("init_web0", DATA_W'(ram_web0), '0);
      check("init_wmask0", DATA_W'(ram_wmask0), DATA_W'({NBANKS*BYTES{1'b1}}));
      check("init_din0", DATA_W'(|ram_din0), '0);
      for (int k = 0; k < NBANKS; k++)
        check("init_addr0", DATA_W'(ram_addr0[k*BANK_ADDR_W +: BANK_ADDR_W]), DATA_W'(n - 1));
`endif
      @(negedge clk);
      junk();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.RW0_en = 1'b0; bus.RW0_wmode = 1'b0; bus.RW0_addr = '0;
    bus.RW0_wdata = '0; bus.RW0_wmask = '0;
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;

    do_reset(3);
    check("ram_clk", DATA_W'(ram_clk), '0);
    check("csb1", DATA_W'(ram_csb1), DATA_W'({NBANKS{1'b1}}));
    check("addr1", DATA_W'(ram_addr1), DATA_W'({NBANKS*BANK_ADDR_W{1'b1}}));
`ifdef MARMOT_SRAM_INIT_EN
    wait_init(200, n_edges);
    do_reset(1);
`endif
    wait_init(FILL_EDGES + 50, n_edges);
    check("init_edges", DATA_W'(n_edges), DATA_W'(FILL_EDGES));

`ifdef MARMOT_SRAM_INIT_EN
    rd(12'h3FF);
    for (int i = 0; i < 16; i++) rd(int'($urandom_range(0, DEPTH - 1)));
`endif
    for (int a = 0; a < DEPTH; a++) wr(a, {$urandom, $urandom}, '1);

    for (int k = 0; k < NBANKS; k++) wr(k*BDEPTH + 7, 64'hA5A5_0000_0000_0001 + 64'(k), '1);
    for (int k = 0; k < NBANKS; k++) rd(k*BDEPTH + 7);
    idle();

    wr(5, 64'h0000_0000_1234_5678, '1);
    rd(5);
    repeat (5) idle();
    wr(6, 64'h0000_0000_FFFF_FFFF, '1);
    repeat (2) idle();

    wr(9, '0, '1);
    wr(9, '1, 2'b01);
    rd(9);
    idle();

    for (int i = 0; i < 800; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 2) idle();
      else if (r < 5) wr(int'($urandom_range(0, DEPTH - 1)), {$urandom, $urandom}, MASK_W'($urandom));
      else rd(int'($urandom_range(0, DEPTH - 1)));
    end

    rd(5);
    idle();
    do_reset(2);
    wait_init(FILL_EDGES + 50, n_edges);
    check("reinit_edges", DATA_W'(n_edges), DATA_W'(FILL_EDGES));
`ifdef MARMOT_SRAM_INIT_EN
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
`endif
    rd(5);
    wr(0, {$urandom, $urandom}, '1);
    rd(0);
    repeat (3) idle();

    check("queue_empty", DATA_W'(exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/banked_sram_ext.md
# banked_sram_ext

Parametrised banked SRAM wrapper that maps one Chisel-style `RW0_*` single-port memory onto `2**(ADDR_W-BANK_ADDR_W)` sky130 dual-port macros through their port 0, with port 1 tied off. It serves as the common wrapper generation for the D-/I-cache data and tag arrays. Compared with the fixed-size wrappers, it adds three things:
- a registered read-bank select with an output hold register, so `RW0_rdata` is stable between reads;
- write-mask expansion for any mask granularity;
- an optional post-reset zero-fill sequencer.

## Interface
- `ADDR_W`, default 10: word-address width of `RW0_addr`.
- `BANK_ADDR_W`, default 9: macro address width (512 words per bank). `NBANKS = 2**(ADDR_W-BANK_ADDR_W)`; `ADDR_W >= BANK_ADDR_W`.
- `DATA_W`, default 32: word width, equal to the macro width (32 or 64).
- `MASK_W`, default 4: `RW0_wmask` width. `(DATA_W/8) % MASK_W == 0`.
- `RW0_clk` input, 1: single clock for the wrapper and all macros.
- `reset` input, 1: synchronous, active-high.
- `RW0_addr` input, `ADDR_W`: the upper `ADDR_W-BANK_ADDR_W` bits select the bank; the low `BANK_ADDR_W` bits are the macro address.
- `RW0_en` input, 1: access enable.
- `RW0_wmode` input, 1: 1 = write, 0 = read.
- `RW0_wmask` input, `MASK_W`: per-lane write enable.
- `RW0_wdata` input, `DATA_W`: write data.
- `RW0_rdata` output, `DATA_W`: read data.
- `init_done` output, 1: wrapper accepts accesses.
- `ram_clk` output, `NBANKS`: per-bank macro clock, equal to `RW0_clk`.
- `ram_csb0` output, `NBANKS`: port-0 chip select, active-low.
- `ram_web0` output, `NBANKS`: port-0 write enable, active-low.
- `ram_wmask0` output, `NBANKS*DATA_W/8`: flattened byte masks; bank k occupies slice k.
- `ram_addr0` output, `NBANKS*BANK_ADDR_W`: flattened port-0 addresses.
- `ram_din0` output, `NBANKS*DATA_W`: flattened write data.
- `ram_dout0` input, `NBANKS*DATA_W`: flattened macro read data.
- `ram_csb1` output, `NBANKS`: port-1 chip select, constant all-ones.
- `ram_addr1` output, `NBANKS*BANK_ADDR_W`: port-1 address, constant all-ones.

## Operation
- **Bank decode:** `sel = RW0_addr[ADDR_W-1:BANK_ADDR_W]`. In state `READY`:
  - `ram_csb0[k] = ~(RW0_en & sel==k)`.
  - `ram_web0[k] = ~RW0_wmode`.
  - `ram_addr0` and `ram_din0` are broadcast to every bank.
- **Mask expansion:** each `RW0_wmask[i]` is replicated `R=(DATA_W/8)/MASK_W` times into byte bits `[i*R +: R]` of every bank's mask.
- **Read tracking:** the registers `rd_sel` (one-hot, `NBANKS` bits) and `rd_pend` capture `~ram_csb0 & ~RW0_wmode` on each edge.
- **Read data:** when `rd_pend`, `RW0_rdata` = `ram_dout0` slice of the one-hot bank, and the `hold` register loads that value. Otherwise `RW0_rdata = hold`.
- **Writes** never update `hold`.
- **FSM** (2 bits):
  - `RESET`: entered while `reset` is high. All `ram_csb0`/`ram_web0` = 1, `init_done` = 0, `hold` = 0, `rd_pend` = 0, `rd_sel` = 0, counter = 0.
  - `RESET` → `INIT` on the first edge with `reset` low (macro compiled in), otherwise → `READY`.
  - `INIT`: every bank has `csb0` = 0, `web0` = 0, all-ones mask, `din0` = 0, `addr0` = counter. The counter increments each cycle. `RW0_*` inputs are ignored and `RW0_rdata` = `hold` = 0.
  - `INIT` → `READY` on the edge where the counter equals `2**BANK_ADDR_W-1`.
  - `READY`: normal operation. `init_done` = 1.
- **Reset mid-operation:** `reset` high in any state returns to `RESET` on the next edge. An interrupted zero-fill restarts from address 0.
- **Out-of-order use:** an access presented while `init_done` = 0 is dropped and is not reported as an error.

## Timing
- **Read latency:** 1 cycle. Read at edge N → data on `RW0_rdata` after edge N+1, held until the next read's data.
- **Write:** committed at edge N. A read of the same address at N+1 returns the new data at N+2.
- **Back-to-back accesses:** reads to different banks on consecutive cycles each return their own bank's data one cycle later with no bubble.
- **Zero-fill:** `init_done` rises exactly `2**BANK_ADDR_W + 1` edges after the first edge with `reset` low.
- **Outputs in reset:** `ram_clk` follows the clock; all other outputs are as listed under `RESET`.

## Configuration
- `MARMOT_SRAM_INIT_EN` defined: the `INIT` state, the counter and the zero-fill behaviour are compiled in.
- `MARMOT_SRAM_INIT_EN` undefined: the FSM goes `RESET` → `READY`, and `init_done` = 1 one edge after reset is released. Macro contents are undefined until written.

## Test plan
- **Zero-fill:** `ADDR_W`=10 with the macro defined; release reset → exactly 512 cycles with every bank showing `csb0`=0, `web0`=0, `din0`=0, and `addr0` running 0..511. `init_done`=1 on cycle 513. Then read `0x3FF` → `RW0_rdata`=0.
- **Bank decode and read latency:** `ADDR_W`=11, `DATA_W`=64 (4 banks). Write `0xA5A5_0000_0000_0001 + k` to address `k*512+7` for k=0..3. Back-to-back reads of the four addresses → each value appears exactly 1 cycle after its request, with only bank k's `csb0` low.
- **Hold:** read `0x005` = `0x1234_5678`, then idle 5 cycles, then write `0x006` = `0xFFFF_FFFF` → `RW0_rdata` stays `0x1234_5678` throughout.
- **Mask expansion:** `DATA_W`=64, `MASK_W`=2. Write `0xFFFF_FFFF_FFFF_FFFF` with mask `2'b01` over existing 0 → `ram_wmask0` slice = `8'h0F`; read back = `0x0000_0000_FFFF_FFFF`.
- **Reset mid-init:** assert `reset` for 1 cycle at init count 200 → the counter restarts at 0, and `init_done` rises 513 edges after the second release.
- **Macro undefined:** `init_done`=1 one edge after reset release; a write/read of `0x000` succeeds on the next cycles.
